// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432: shifts in key+checksum, exposes key only if the XOR checksum matches.
// Latency: key_valid/err one edge after the CHECK state; backpressure: sin_ready high only in SHIFT.
module c432_key_loader #(
    parameter int KEY_W = 16,
    parameter int CHK_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);
    localparam int FRAME_W = KEY_W + CHK_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int NIB_N   = KEY_W / CHK_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_ARMED = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic               err_q, err_d;
    logic [CHK_W-1:0]   chk_calc;

    always_comb begin
        chk_calc = '0;
        for (int i = 0; i < NIB_N; i++) begin
            chk_calc = chk_calc ^ shadow_q[CHK_W + i*CHK_W +: CHK_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        if (clear) begin
            state_d     = ST_IDLE;
            key_d       = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
        end else if (start) begin
            state_d     = ST_SHIFT;
            cnt_d       = '0;
            shadow_d    = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (sin_valid) begin
                        shadow_d = {shadow_q[FRAME_W-2:0], sin_data};
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // key_out is only ever loaded here, so a partial frame never leaks out
                    if (chk_calc == shadow_q[CHK_W-1:0]) begin
                        key_d       = shadow_q[FRAME_W-1:CHK_W];
                        key_valid_d = 1'b1;
                        state_d     = ST_ARMED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                ST_IDLE, ST_ARMED, ST_ERROR: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    assign sin_ready = (state_q == ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_c432_key_loader.sv
// Randomized bench for c432_key_loader against a frame-level reference model.
module tb_c432_key_loader;
    logic        clk = 1'b0;
    logic        rst_n, start, clear, sin_valid, sin_data;
    logic        sin_ready, key_valid, busy, err;
    logic [15:0] key_out;
    int          errors = 0;
    int          checks = 0;

    c432_key_loader #(.KEY_W(16), .CHK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
        .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference checksum: XOR of the four key nibbles
    function automatic logic [3:0] ref_chk(input logic [15:0] k);
        return k[15:12] ^ k[11:8] ^ k[7:4] ^ k[3:0];
    endfunction

    // Packed view {key_out, key_valid, err, busy, sin_ready}
    task automatic expect_out(input string tag, input logic [15:0] k, input logic kv,
                              input logic e, input logic b, input logic r);
        check(tag, {12'b0, key_out, key_valid, err, busy, sin_ready}, {12'b0, k, kv, e, b, r});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("start", 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_bits(input logic [19:0] frame, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(maxgap, 0);
            for (int j = 0; j < g; j++) begin
                sin_valid = 1'b0;
                sin_data  = 1'($urandom);
                tick();
                expect_out("gap", 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            end
            sin_valid = 1'b1;
            sin_data  = frame[19-i];
            tick();
            sin_valid = 1'b0;
            if (i < 19) expect_out("shift", 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic hold_check(input logic [15:0] k, input logic kv, input logic e);
        for (int i = 0; i < 3; i++) begin
            sin_valid = 1'($urandom);
            sin_data  = 1'($urandom);
            tick();
            expect_out("hold", k, kv, e, 1'b0, 1'b0);
        end
        sin_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] k, input logic [3:0] c, input int maxgap);
        pulse_start();
        send_bits({k, c}, 20, maxgap);
        expect_out("check_state", 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        if (c == ref_chk(k)) begin
            expect_out("armed", k, 1'b1, 1'b0, 1'b0, 1'b0);
            hold_check(k, 1'b1, 1'b0);
        end else begin
            expect_out("error", 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            hold_check(16'h0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; clear = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
        tick();
        start = 1'b0;
        tick();
        expect_out("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // IDLE ignores serial traffic
        for (int i = 0; i < 4; i++) begin
            sin_valid = 1'b1;
            sin_data  = 1'($urandom);
            tick();
            expect_out("idle_ignore", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        sin_valid = 1'b0;

        run_frame(16'hA5C3, 4'h0, 0);            // good key
        run_frame(16'hA5C3, 4'h1, 0);            // bad checksum -> ERROR
        pulse_start();                           // start leaves ERROR and clears err
        run_frame(16'hA5C3, 4'h0, 3);            // gaps between bits

        // reset mid-frame
        pulse_start();
        send_bits(20'hA5C30, 7, 0);
        rst_n = 1'b0;
        tick();
        expect_out("mid_reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_frame(16'hA5C3, 4'h0, 0);

        // re-key from ARMED
        pulse_start();
        send_bits({16'h1234, ref_chk(16'h1234)}, 20, 0);
        tick();
        expect_out("rekey", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(16'h1234, 4'h0, 0);            // wrong checksum for this key

        // start+clear together from every state: clear wins
        for (int s = 0; s < 5; s++) begin
            case (s)
                1: begin pulse_start(); send_bits(20'h5A3C1, 5, 0); end
                2: begin pulse_start(); send_bits(20'h5A3C1, 20, 0); end
                3: run_frame(16'hA5C3, 4'h0, 0);
                4: run_frame(16'hA5C3, 4'h7, 0);
                default: ;
            endcase
            start = 1'b1;
            clear = 1'b1;
            tick();
            start = 1'b0;
            clear = 1'b0;
            expect_out("start_clear", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // randomized frames with occasional restarts and aborts
        for (int n = 0; n < 30; n++) begin
            logic [15:0] k;
            logic [3:0]  c;
            k = 16'($urandom);
            c = ($urandom_range(1, 0) == 1) ? ref_chk(k) : 4'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                pulse_start();
                send_bits(20'($urandom), $urandom_range(18, 1), 1);
                if ($urandom_range(1, 0) == 1) begin
                    clear = 1'b1;
                    tick();
                    clear = 1'b0;
                    expect_out("clear_abort", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
            run_frame(k, c, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
